// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: FSM state encoding and timeout read-data pattern shared by the APB master arbiter.
package apb_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;
   localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/apb_rr_prio.sv
// apb_rr_prio: combinational round-robin pick of the first requester after last_owner.
module apb_rr_prio #(
   parameter int NUM_MASTERS = 2,
   localparam int OW = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [OW-1:0]          last_owner,
   output logic [OW-1:0]          grant,
   output logic                   any_req
);
   // Scan from farthest to nearest so the nearest set request wins.
   always_comb begin
      grant = '0;
      for (int k = NUM_MASTERS; k >= 1; k--)
         if (req[(int'(last_owner) + k) % NUM_MASTERS]) grant = OW'((int'(last_owner) + k) % NUM_MASTERS);
   end
   assign any_req = |req;
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB bus among NUM_MASTERS requesters, one transfer in flight.
// Define APB_TIMEOUT_EN to end ACCESS after TIMEOUT_CYCLES without PREADY (err_o=1, rdata_o=DEADBEEF).
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int APB_NUM_SLAVES = 8,
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int NM = NUM_MASTERS,
   localparam int NS = APB_NUM_SLAVES,
   localparam int AW = APB_ADDR_WIDTH,
   localparam int SW = $clog2(NS),
   localparam int AL = SW + AW,
   localparam int OW = $clog2(NM)
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic [NM-1:0]    req_i,
   input  logic [NM-1:0]    we_i,
   input  logic [NM*AL-1:0] addr_i,
   input  logic [NM*32-1:0] wdata_i,
   output logic [NM-1:0]    done_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic [NS-1:0]    PSEL,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [AW-1:0]    PADDR,
   output logic [31:0]      PWDATA,
   input  logic [NS*32-1:0] PRDATA,
   input  logic [NS-1:0]    PREADY,
   input  logic [NS-1:0]    PSLVERR
);
   state_t        state;
   logic [OW-1:0] owner, last_owner, grant;
   logic [SW-1:0] sel;
   logic [AL-1:0] req_addr;
   logic          any_req, to_hit, ready;
   apb_rr_prio #(.NUM_MASTERS(NM)) u_rr (
      .req(req_i), .last_owner(last_owner), .grant(grant), .any_req(any_req)
   );
   assign req_addr = addr_i[int'(grant)*AL +: AL];
   assign ready    = PREADY[sel] | to_hit;
`ifdef APB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] cnt;
   always_ff @(posedge ACLK)
      cnt <= (!ARESETn || state != ACCESS) ? '0 : cnt + 1'b1;
   assign to_hit = (state == ACCESS) && (cnt == TW'(TIMEOUT_CYCLES - 1)) && !PREADY[sel];
`else
   assign to_hit = 1'b0;
`endif
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OW'(NM - 1);
         sel        <= '0;
         PSEL       <= '0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         done_o     <= '0;
         rdata_o    <= '0;
         err_o      <= 1'b0;
      end else begin
         done_o <= '0;
         case (state)
            IDLE: if (any_req) begin
               state  <= SETUP;
               owner  <= grant;
               sel    <= req_addr[AL-1:AW];
               PSEL   <= NS'(1) << req_addr[AL-1:AW];
               PWRITE <= we_i[grant];
               PADDR  <= req_addr[AW-1:0];
               PWDATA <= wdata_i[int'(grant)*32 +: 32];
            end
            SETUP: begin
               state   <= ACCESS;
               PENABLE <= 1'b1;
            end
            ACCESS: if (ready) begin
               state      <= RESP;
               last_owner <= owner;
               done_o     <= NM'(1) << owner;
               rdata_o    <= to_hit ? APB_TIMEOUT_RDATA : PWRITE ? 32'h0 : PRDATA[int'(sel)*32 +: 32];
               err_o      <= to_hit | PSLVERR[sel];
               PSEL       <= '0;
               PENABLE    <= 1'b0;
               PWRITE     <= 1'b0;
               PADDR      <= '0;
               PWDATA     <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
